// File: rtl/l2_operand_feeder.sv
// rtl/l2_operand_feeder.sv - tap-sequenced pixel/weight operand feeder for the layer-2 PE array
module l2_operand_feeder #(
    parameter int TAPS    = 25,
    parameter int DW      = 16,
    parameter int LANES   = 4,
    parameter int KERNELS = 8,
    parameter int DRAIN   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wt_we,
    input  logic [4:0]            i_wt_addr,
    input  logic [KERNELS*DW-1:0] i_wt_data,
    input  logic                  i_start,
    input  logic                  i_pix_valid,
    output logic                  o_pix_ready,
    input  logic [LANES*DW-1:0]   i_pix_0,
    input  logic [LANES*DW-1:0]   i_pix_1,
    input  logic [LANES*DW-1:0]   i_pix_2,
    input  logic [LANES*DW-1:0]   i_pix_3,
    output logic [LANES*DW-1:0]   o_data_0,
    output logic [LANES*DW-1:0]   o_data_1,
    output logic [LANES*DW-1:0]   o_data_2,
    output logic [LANES*DW-1:0]   o_data_3,
    output logic [KERNELS*DW-1:0] o_weight,
    output logic                  o_pe_valid,
    output logic                  o_pe_first,
    output logic                  o_pe_last,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int PW  = LANES * DW;
    localparam int WW  = KERNELS * DW;
    localparam int DCW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [4:0]     tap;
    logic [DCW-1:0] drain_cnt;
    logic           accept;
    logic           last_tap;
    logic [WW-1:0]  wfile [TAPS];

    assign accept   = i_pix_valid && o_pix_ready;
    assign last_tap = (tap == 5'(TAPS - 1));

    // Next-state and state-decoded outputs; ready depends on state only.
    always_comb begin
        state_nx    = state;
        o_pix_ready = 1'b0;
        o_busy      = 1'b1;
        o_done      = 1'b0;
        case (state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) state_nx = S_RUN;
            end
            S_RUN: begin
                o_pix_ready = 1'b1;
                if (accept && last_tap) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_cnt == DCW'(DRAIN - 1)) state_nx = S_DONE;
            end
            S_DONE: begin
                o_done   = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State register plus tap and drain counters; tap saturates at the last tap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            tap       <= '0;
            drain_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && i_start) begin
                tap <= '0;
            end else if (accept && !last_tap) begin
                tap <= tap + 5'd1;
            end
            if (state == S_DRAIN) begin
                drain_cnt <= drain_cnt + DCW'(1);
            end else begin
                drain_cnt <= '0;
            end
        end
    end

    // Weight file: loaded only while idle, deliberately not reset so it survives rst.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && i_wt_we && i_wt_addr < 5'(TAPS)) begin
            wfile[i_wt_addr] <= i_wt_data;
        end
    end

    // Operand registers: capture on each accepted beat, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_data_0   <= '0;
            o_data_1   <= '0;
            o_data_2   <= '0;
            o_data_3   <= '0;
            o_weight   <= '0;
            o_pe_valid <= 1'b0;
            o_pe_first <= 1'b0;
            o_pe_last  <= 1'b0;
        end else begin
            o_pe_valid <= accept;
            if (accept) begin
                o_data_0   <= i_pix_0;
                o_data_1   <= i_pix_1;
                o_data_2   <= i_pix_2;
                o_data_3   <= i_pix_3;
                o_weight   <= wfile[tap];
                o_pe_first <= (tap == 5'd0);
                o_pe_last  <= last_tap;
            end
        end
    end

    logic [PW-1:0] unused_pw;
    assign unused_pw = '0;

endmodule

// File: tb/tb_l2_operand_feeder.sv
// tb/tb_l2_operand_feeder.sv - directed self-checking bench for l2_operand_feeder
module tb_l2_operand_feeder;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_wt_we;
    logic [4:0]   i_wt_addr;
    logic [127:0] i_wt_data;
    logic         i_start;
    logic         i_pix_valid;
    logic         o_pix_ready;
    logic [63:0]  i_pix_0, i_pix_1, i_pix_2, i_pix_3;
    logic [63:0]  o_data_0, o_data_1, o_data_2, o_data_3;
    logic [127:0] o_weight;
    logic         o_pe_valid, o_pe_first, o_pe_last, o_busy, o_done;

    int n_checks = 0;
    int n_errors = 0;

    l2_operand_feeder dut (
        .clk         (clk),
        .rst         (rst),
        .i_wt_we     (i_wt_we),
        .i_wt_addr   (i_wt_addr),
        .i_wt_data   (i_wt_data),
        .i_start     (i_start),
        .i_pix_valid (i_pix_valid),
        .o_pix_ready (o_pix_ready),
        .i_pix_0     (i_pix_0),
        .i_pix_1     (i_pix_1),
        .i_pix_2     (i_pix_2),
        .i_pix_3     (i_pix_3),
        .o_data_0    (o_data_0),
        .o_data_1    (o_data_1),
        .o_data_2    (o_data_2),
        .o_data_3    (o_data_3),
        .o_weight    (o_weight),
        .o_pe_valid  (o_pe_valid),
        .o_pe_first  (o_pe_first),
        .o_pe_last   (o_pe_last),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] wt_word(input int k);
        logic [15:0] e;
        e = 16'h0100 + 16'(k);
        return {8{e}};
    endfunction

    // Channel 0 carries the bare tap index; other channels tag each lane distinctly.
    function automatic logic [63:0] pix_word(input int ch, input int k);
        logic [63:0] w;
        if (ch == 0) return 64'(k);
        w = '0;
        for (int l = 0; l < 4; l++) w[l*16 +: 16] = 16'((ch << 12) | (l << 8) | k);
        return w;
    endfunction

    task automatic drive_pix(input int k);
        i_pix_0 = pix_word(0, k);
        i_pix_1 = pix_word(1, k);
        i_pix_2 = pix_word(2, k);
        i_pix_3 = pix_word(3, k);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, 128'(o_pe_valid), 128'd0);
        check({tag, "_done"},  128'(o_done),     128'd0);
        check({tag, "_busy"},  128'(o_busy),     128'd0);
        check({tag, "_ready"}, 128'(o_pix_ready), 128'd0);
        check({tag, "_first"}, 128'(o_pe_first), 128'd0);
        check({tag, "_last"},  128'(o_pe_last),  128'd0);
        check({tag, "_data"},  {o_data_3, o_data_2} | {o_data_1, o_data_0}, 128'd0);
        check({tag, "_wt"},    o_weight, 128'd0);
    endtask

    // One full window. gaps drops valid on even cycles; poke injects illegal
    // weight writes and starts during RUN and DONE.
    task automatic run_window(input bit gaps, input bit poke);
        int  c, tap, pend, last_acc, done_c;
        bit  exp_rdy, exp_done, acc, done_seen;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        c = 1; tap = 0; pend = -1; last_acc = -1; done_c = -1; done_seen = 1'b0;
        check("busy_after_start", 128'(o_busy), 128'd1);
        while (c < 200 && !done_seen) begin
            check("pe_valid", 128'(o_pe_valid), 128'(pend >= 0));
            if (pend >= 0) begin
                check("data_0", 128'(o_data_0), 128'(pix_word(0, pend)));
                check("data_1", 128'(o_data_1), 128'(pix_word(1, pend)));
                check("data_2", 128'(o_data_2), 128'(pix_word(2, pend)));
                check("data_3", 128'(o_data_3), 128'(pix_word(3, pend)));
                check("weight", o_weight, wt_word(pend));
                check("pe_first", 128'(o_pe_first), 128'(pend == 0));
                check("pe_last", 128'(o_pe_last), 128'(pend == 24));
            end
            exp_rdy  = (tap < 25);
            exp_done = (last_acc >= 0) && (c == last_acc + 4);
            check("pix_ready", 128'(o_pix_ready), 128'(exp_rdy));
            check("done", 128'(o_done), 128'(exp_done));
            if (exp_done) begin
                done_seen = 1'b1;
                done_c    = c;
            end
            i_pix_valid = exp_rdy && (!gaps || c[0]);
            drive_pix(tap);
            i_wt_we   = poke && (c == 3);
            i_wt_addr = 5'd5;
            i_wt_data = '1;
            i_start   = poke && (c == 7 || exp_done);
            acc  = i_pix_valid;
            pend = acc ? tap : -1;
            if (acc) begin
                tap++;
                last_acc = c;
            end
            tick();
            c++;
        end
        i_pix_valid = 1'b0;
        i_start     = 1'b0;
        i_wt_we     = 1'b0;
        check("window_done_seen", 128'(done_seen), 128'd1);
        check("taps_accepted", 128'(tap), 128'd25);
        if (!gaps) check("done_cycle", 128'(done_c), 128'd29);
        check("busy_after_done", 128'(o_busy), 128'd0);
        check("done_one_cycle", 128'(o_done), 128'd0);
    endtask

    initial begin
        rst = 1'b1; i_wt_we = 1'b0; i_wt_addr = '0; i_wt_data = '0;
        i_start = 1'b0; i_pix_valid = 1'b0;
        drive_pix(0);
        tick();
        tick();
        check_outputs_zero("reset");
        rst = 1'b0;
        tick();

        for (int k = 0; k < 25; k++) begin
            i_wt_we = 1'b1; i_wt_addr = 5'(k); i_wt_data = wt_word(k);
            tick();
        end
        i_wt_addr = 5'd25; i_wt_data = '1;
        tick();
        i_wt_we = 1'b0;
        tick();

        run_window(1'b0, 1'b0);
        run_window(1'b1, 1'b0);
        run_window(1'b0, 1'b1);
        tick();
        check("no_second_window", 128'(o_busy), 128'd0);

        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            i_pix_valid = 1'b1;
            drive_pix(k);
            tick();
        end
        i_pix_valid = 1'b0;
        rst = 1'b1;
        tick();
        check_outputs_zero("midrst");
        rst = 1'b0;
        tick();
        check("midrst_no_done", 128'(o_done), 128'd0);

        run_window(1'b0, 1'b0);
        run_window(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/l2_operand_feeder.md
# l2_operand_feeder

Operand sequencer on the input side of the layer-2 convolution array. It holds one 5x5 tap set of kernel weights: 25 taps, each carrying 8 kernels x 16 bits. For each output window it accepts 25 pixel beats over a valid/ready stream, each beat being 4 input channels x 4 lanes x 16 bits. It drives the registered pixel words plus the matching weight word to the PE array with a per-tap valid strobe. After the last tap it waits a fixed drain time so the PE accumulators settle, then signals completion.

## Interface
- TAPS, 25, taps per window; must match the PE accumulation length.
- DW, 16, element width in bits.
- LANES, 4, elements per pixel word; pixel word width = LANES*DW = 64.
- KERNELS, 8, kernels per weight word; weight word width = KERNELS*DW = 128.
- DRAIN, 3, cycles waited after the last tap before o_done.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- i_wt_we  in  1  weight write enable.
- i_wt_addr  in  5  tap index for the weight write.
- i_wt_data  in  128  weight word for that tap.
- i_start  in  1  one-cycle pulse that begins a window.
- i_pix_valid  in  1  pixel beat valid.
- o_pix_ready  out  1  pixel beat ready.
- i_pix_0..i_pix_3  in  64 each  channel 0..3 pixel words of the current tap.
- o_data_0..o_data_3  out  64 each  registered pixel words to the PEs.
- o_weight  out  128  registered weight word to the PEs.
- o_pe_valid  out  1  o_data_* and o_weight hold a live tap this cycle.
- o_pe_first  out  1  live tap is tap 0; PE clears its accumulator.
- o_pe_last  out  1  live tap is tap TAPS-1.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle window-complete pulse.

## Operation
- Weight file: TAPS x 128-bit registers.
  - Written only in IDLE when i_wt_we=1 and i_wt_addr<TAPS.
  - Writes in any other state, or with i_wt_addr>=TAPS, are dropped.
  - Not reset; contents survive rst.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: i_start=1 → RUN, tap counter cleared to 0. i_start in any other state is ignored.
  - RUN: o_pix_ready=1. A beat is accepted when i_pix_valid && o_pix_ready. On each accepted beat:
    - i_pix_k is captured into o_data_k.
    - wfile[tap] is captured into o_weight.
    - o_pe_first=(tap==0) and o_pe_last=(tap==TAPS-1) are registered.
    - tap increments.
  - RUN, last tap: accepting the beat at tap==TAPS-1 → DRAIN, drain counter cleared.
  - RUN, stall: with no accepted beat, o_pe_valid=0 next cycle and tap holds. The PEs see gaps but accumulate only valid taps.
  - DRAIN: o_pix_ready=0. Counts DRAIN cycles, then → DONE.
  - DONE: o_done=1 for exactly one cycle, then → IDLE.
- o_data_*, o_weight and the first/last flags hold their last value when o_pe_valid=0.
- No arithmetic is done on the operands; lane and kernel order is passed through bit-exact.
  - Lane j = bits [j*16+:16].
  - Kernel i = bits [i*16+:16].
- Tap counter is 5 bits and never exceeds TAPS-1; no wrap inside a window.

## Timing
- Reset values: every output 0, FSM in IDLE, tap and drain counters 0.
- Reset in any state, including mid-RUN or DRAIN: the window is aborted, o_pe_valid=0 and o_done=0 the next cycle, and no partial-window done pulse is produced.
- Start: i_start at cycle t gives o_busy=1 and o_pix_ready=1 at t+1.
- Operand latency: a beat accepted at cycle n appears on o_data_*/o_weight with o_pe_valid=1 at n+1.
- Window latency, no stalls, start at t:
  - Beats accepted t+1..t+25.
  - o_pe_valid t+2..t+26.
  - DRAIN t+26..t+28.
  - o_done at t+29.
  - o_busy falls at t+30.
- Earliest restart: the next i_start is accepted at t+30, i.e. the cycle o_busy is low.
- o_pix_ready is combinational from state only; it never depends on i_pix_valid.

## Test plan
- Weight load and bypass: write wfile[k]={8{k[15:0]+16'h0100}} for k=0..24, start, send 25 beats with i_pix_0=k → o_weight=0x0100+k replicated and o_data_0=k at the cycle after each accept. o_pe_first only on k=0, o_pe_last only on k=24, o_done exactly 29 cycles after i_start.
- Backpressure gaps: drop i_pix_valid every other cycle → exactly 25 o_pe_valid pulses in tap order, with o_pe_valid=0 in each gap cycle and o_done 4 cycles after the last accepted beat.
- Illegal control: i_wt_we with addr 5 during RUN, and addr 25 in IDLE → the weight file is unchanged on readback through the next window. i_start during RUN and DONE → ignored, no second window.
- Reset mid-window: assert rst after 10 beats → all outputs 0 next cycle. A following full window produces 25 taps starting with o_pe_first, and o_done fires once.
- Back-to-back windows: i_start in the first cycle o_busy=0 → second window timing is identical to the first, and no beat is lost or duplicated.
